instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, 24'd10, PC of the first fetch after reset.
REQ-002 Parameter PC_STEP, 24'd3, byte increment between sequential instructions.
REQ-003 Clock  input  1  single clock; all state updates on the rising edge.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 Halt  input  1  level; high stops new fetch requests.
REQ-006 Redirect  input  1  one-cycle pulse; branch/jump taken by the datapath.
REQ-007 RedirectPC  input  24  target PC, sampled when Redirect=1.
REQ-008 ImemReq  output  1  instruction-memory read strobe.
REQ-009 ImemAddr  output  24  read address, valid when ImemReq=1.
REQ-010 ImemData  input  24  read data, valid exactly one cycle after ImemReq.
REQ-011 InstrValid  output  1  FIFO head holds a valid instruction.
REQ-012 InstrReady  input  1  datapath accepts the head this cycle.
REQ-013 Instr  output  24  head instruction word; opcode in [23:20].
REQ-014 InstrPC  output  24  PC of the head instruction.
REQ-015 InstrPC3  output  24  InstrPC + PC_STEP, modulo 2^24.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and HALTED.
REQ-017 The FSM SHALL move IDLE->RUN on the first rising edge after Reset_n deasserts.
REQ-018 The FSM SHALL move RUN->HALTED when Halt=1 and HALTED->RUN when Halt=0.
REQ-019 In RUN the block SHALL assert ImemReq when (fifo_count + inflight - pop) < 2 and Redirect=0, where pop = InstrValid & InstrReady.
REQ-020 Each request SHALL drive ImemAddr = fetch_pc, then set fetch_pc = fetch_pc + PC_STEP, modulo 2^24 with no carry out.
REQ-021 Each response SHALL be pushed into a 2-entry FIFO as {ImemData, its PC} one cycle after its request, unless a flush discarded it.
REQ-022 Instr, InstrPC and InstrPC3 SHALL come from the FIFO head; the head SHALL pop only when InstrValid & InstrReady.
REQ-023 The FIFO SHALL accept a push and a pop in the same cycle, including when it is full.
REQ-024 A FIFO overflow SHALL be impossible by construction of the credit rule in REQ-019.
REQ-025 When Redirect=1, the block SHALL empty the FIFO, discard any in-flight response, set fetch_pc = RedirectPC, and issue no request that cycle.
REQ-026 After a Redirect, the first request SHALL go to RedirectPC in the next cycle (RUN state), and InstrValid SHALL return two cycles after Redirect.
REQ-027 A Redirect SHALL override a simultaneous pop; that pop still completes, and the handshake is not repeated.
REQ-028 A Redirect while HALTED SHALL still flush and load fetch_pc; no request is issued until Halt=0.
REQ-029 In HALTED, no new request SHALL issue; an in-flight response SHALL still be pushed, and the FIFO SHALL still drain.
REQ-030 With InstrReady held at 1 and no Redirect, throughput SHALL be one instruction per cycle.

Reset
REQ-031 While Reset_n=0, the block SHALL hold state=IDLE, fetch_pc=RESET_PC, fifo_count=0, inflight=0, ImemReq=0, ImemAddr=0, InstrValid=0, and Instr, InstrPC and InstrPC3 at 0.
REQ-032 A Reset_n assertion mid-operation SHALL take effect asynchronously and discard all in-flight and buffered instructions.

Configuration
REQ-033 With IF_PERF_EN defined, the block SHALL add output FlushCount (16-bit) counting Redirect pulses, saturating at 16'hFFFF and reset to 0.
REQ-034 Without IF_PERF_EN, the FlushCount port and its logic SHALL be absent.

Structure
REQ-035 Shared package cpu24_pkg SHALL hold the 24-bit word width, PC_STEP, RESET_PC, and the FSM state enum.
REQ-036 The FIFO SHALL be a sub-module named fetch_fifo (2 entries, 48-bit payload, push/pop/flush).

Verification
REQ-037 Reset release with InstrReady=1 -> ImemAddr = 10, 13, 16, ... one per cycle; InstrPC follows one cycle later; InstrPC3 = InstrPC+3.
REQ-038 InstrReady=0 for 5 cycles -> at most 2 buffered, ImemReq low once credits are exhausted, no instruction lost or duplicated on resume.
REQ-039 Redirect with RedirectPC=24'h000100 while FIFO full -> InstrValid=0 next cycle, ImemAddr=24'h000100 next cycle, first InstrPC=24'h000100.
REQ-040 fetch_pc=24'hFFFFFE -> next ImemAddr = 24'h000001 (wrap).
REQ-041 Halt=1 for 4 cycles -> no ImemReq, FIFO drains; Redirect to 24'h000040 during Halt, then Halt=0 -> first request at 24'h000040.
REQ-042 Reset_n pulsed low mid-stream, with IF_PERF_EN defined and 3 prior Redirects -> all outputs return to reset values, FlushCount goes 3->0, fetch restarts at 10.

Source files
------------

// File: rtl/cpu24_pkg.sv
// Shared definitions for the 24-bit CPU fetch path: word width, PC constants,
// fetch FSM states and the fetch FIFO payload layout.
package cpu24_pkg;

    localparam int unsigned WORD_W     = 24;
    localparam int unsigned FIFO_DEPTH = 2;

    localparam logic [WORD_W-1:0] PC_STEP  = 24'd3;
    localparam logic [WORD_W-1:0] RESET_PC = 24'd10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
    } fetch_entry_t;

    // Sequential PC advance; the carry out of bit 23 is dropped.
    function automatic logic [WORD_W-1:0] pc_next(input logic [WORD_W-1:0] pc,
                                                   input logic [WORD_W-1:0] step);
        return pc + step;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fall-through FIFO for {instruction, PC} pairs; a push into an empty
// FIFO is visible at the head in the same cycle. Supports push, pop and flush.
module fetch_fifo
    import cpu24_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic         head_valid_o,
    output fetch_entry_t head_o,
    output logic [1:0]   count_o
);

    fetch_entry_t mem0_q, mem0_d;
    fetch_entry_t mem1_q, mem1_d;
    logic [1:0]   count_q, count_d;
    logic         pop;

    assign head_valid_o = (count_q != 2'd0) || push_i;
    assign head_o       = (count_q != 2'd0) ? mem0_q : push_data_i;
    assign count_o      = count_q;
    assign pop          = pop_i & head_valid_o;

    always_comb begin
        mem0_d  = mem0_q;
        mem1_d  = mem1_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            case (count_q)
                2'd0: begin
                    // A bypassed push that is popped at once is never stored.
                    if (push_i && !pop) begin
                        mem0_d  = push_data_i;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    case ({push_i, pop})
                        2'b11: mem0_d = push_data_i;
                        2'b01: count_d = 2'd0;
                        2'b10: begin
                            mem1_d  = push_data_i;
                            count_d = 2'd2;
                        end
                        default: ;
                    endcase
                end
                default: begin
                    case ({push_i, pop})
                        2'b11: begin
                            mem0_d = mem1_q;
                            mem1_d = push_data_i;
                        end
                        2'b01: begin
                            mem0_d  = mem1_q;
                            count_d = 2'd1;
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem0_q  <= '0;
            mem1_q  <= '0;
            count_q <= '0;
        end else begin
            mem0_q  <= mem0_d;
            mem1_q  <= mem1_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: credit-based requests into a 2-entry fetch FIFO with
// redirect flush and halt. Optional IF_PERF_EN adds a saturating FlushCount output.
module instruction_fetch
#(
    parameter logic [cpu24_pkg::WORD_W-1:0] RESET_PC = cpu24_pkg::RESET_PC,
    parameter logic [cpu24_pkg::WORD_W-1:0] PC_STEP  = cpu24_pkg::PC_STEP
)
(
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Halt,
    input  logic        Redirect,
    input  logic [23:0] RedirectPC,
    output logic        ImemReq,
    output logic [23:0] ImemAddr,
    input  logic [23:0] ImemData,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [23:0] Instr,
    output logic [23:0] InstrPC,
    output logic [23:0] InstrPC3
`ifdef IF_PERF_EN
    ,
    output logic [15:0] FlushCount
`endif
);

    import cpu24_pkg::*;

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [WORD_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;

    logic              req;
    logic              push;
    logic              pop;
    logic [1:0]        fifo_count;
    logic [2:0]        credit_used;
    logic              head_valid;
    fetch_entry_t      head;
    fetch_entry_t      push_entry;

    assign pop         = head_valid & InstrReady;
    // A response landing in a redirect cycle is dropped before it reaches the FIFO.
    assign push        = inflight_q & ~Redirect;
    assign push_entry  = '{instr: ImemData, pc: inflight_pc_q};
    assign credit_used = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

    always_comb begin
        state_d    = state_q;
        req        = 1'b0;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
                // Halt suppresses the request in the cycle it rises, not only once HALTED.
                if (Halt) begin
                    state_d = HALTED;
                end else begin
                    req = !Redirect && (credit_used < 3'd2);
                end
            end
            HALTED: begin
                if (!Halt) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        if (Redirect) begin
            fetch_pc_d = RedirectPC;
        end else if (req) begin
            fetch_pc_d = pc_next(fetch_pc_q, PC_STEP);
        end
    end

    always_comb begin
        inflight_d    = req;
        inflight_pc_d = inflight_pc_q;
        if (req) begin
            inflight_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo u_fetch_fifo (
        .clk_i        (Clock),
        .rst_ni       (Reset_n),
        .push_i       (push),
        .push_data_i  (push_entry),
        .pop_i        (pop),
        .flush_i      (Redirect),
        .head_valid_o (head_valid),
        .head_o       (head),
        .count_o      (fifo_count)
    );

    assign ImemReq    = req;
    assign ImemAddr   = req ? fetch_pc_q : '0;
    assign InstrValid = head_valid;
    assign Instr      = head_valid ? head.instr : '0;
    assign InstrPC    = head_valid ? head.pc : '0;
    assign InstrPC3   = head_valid ? pc_next(head.pc, PC_STEP) : '0;

`ifdef IF_PERF_EN
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (Redirect && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            flush_cnt_q <= '0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign FlushCount = flush_cnt_q;
`endif

endmodule
